// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants, FSM state type and helpers for the LSU front end.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    // Byte lane offset actually used by an access: halves ignore a[0], words ignore both.
    function automatic logic [1:0] lane_off(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_B, F3_BU: lane_off = a;
            F3_H, F3_HU: lane_off = {a[1], 1'b0};
            default:     lane_off = 2'b00;
        endcase
    endfunction

    // Encodings outside B/H/W/BU/HU behave as a word access but flag an error.
    function automatic logic is_reserved(input logic [2:0] f3);
        is_reserved = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane shift / byte mask and load extract / extend (combinational).
// LSU_MISALIGN_CHECK_EN: when defined, misaligned H/W accesses are flagged via misalign_o.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      st_funct3_i,
    input  logic [1:0]      st_addr_lo_i,
    input  logic [XLEN-1:0] st_wdata_i,
    output logic [3:0]      st_wmask_o,
    output logic [XLEN-1:0] st_wdata_o,
    output logic            st_misalign_o,
    output logic            st_err_o,
    input  logic [2:0]      ld_funct3_i,
    input  logic [1:0]      ld_addr_lo_i,
    input  logic [XLEN-1:0] ld_rdata_i,
    output logic [XLEN-1:0] ld_data_o
);

    logic [1:0]  st_off;
    logic [1:0]  ld_off;
    logic [15:0] ld_sh;

    // Store side: place data and byte enables on the addressed lane.
    always_comb begin
        st_off = lane_off(st_funct3_i, st_addr_lo_i);
        case (st_funct3_i)
            F3_B, F3_BU: st_wmask_o = MASK_B << st_off;
            F3_H, F3_HU: st_wmask_o = MASK_H << st_off;
            default:     st_wmask_o = MASK_W;
        endcase
        st_wdata_o = st_wdata_i << {st_off, 3'b000};
    end

`ifdef LSU_MISALIGN_CHECK_EN
    // Halves must be 2-byte aligned, words (and reserved-as-word) 4-byte aligned.
    always_comb begin
        case (st_funct3_i)
            F3_B, F3_BU: st_misalign_o = 1'b0;
            F3_H, F3_HU: st_misalign_o = st_addr_lo_i[0];
            default:     st_misalign_o = (st_addr_lo_i != 2'b00);
        endcase
    end
`else
    assign st_misalign_o = 1'b0;
`endif

    assign st_err_o = is_reserved(st_funct3_i) | st_misalign_o;

    // Load side: shift the addressed lane down, then sign/zero extend.
    always_comb begin
        ld_off = lane_off(ld_funct3_i, ld_addr_lo_i);
        ld_sh  = 16'(ld_rdata_i >> {ld_off, 3'b000});
        case (ld_funct3_i)
            F3_B:    ld_data_o = {{(XLEN-8){ld_sh[7]}}, ld_sh[7:0]};
            F3_BU:   ld_data_o = {{(XLEN-8){1'b0}}, ld_sh[7:0]};
            F3_H:    ld_data_o = {{(XLEN-16){ld_sh[15]}}, ld_sh};
            F3_HU:   ld_data_o = {{(XLEN-16){1'b0}}, ld_sh};
            default: ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_req.sv
// lsu_mem_req: LSU front end, initiator side of the data-memory valid/ready port.
// LSU_MISALIGN_CHECK_EN: when defined, misaligned H/W ops skip memory and return out_err.
module lsu_mem_req
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int MASK_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wen,
    input  logic [2:0]        in_funct3,
    input  logic [XLEN-1:0]   in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wen,
    output logic [XLEN-1:0]   mem_req_addr,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [MASK_W-1:0] mem_req_wmask,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_rdata,
    output logic              out_err
);

    lsu_state_e      state_q, state_d;
    logic            wen_q;
    logic [2:0]      f3_q;
    logic [1:0]      alo_q;
    logic [XLEN-1:0] req_addr_q, req_wdata_q, rdata_q;
    logic [3:0]      req_wmask_q;
    logic            err_q;

    logic            accept;
    logic [3:0]      st_wmask;
    logic [XLEN-1:0] st_wdata, ld_data;
    logic            st_misalign, st_err;

    lsu_align #(.XLEN(XLEN)) u_align (
        .st_funct3_i   (in_funct3),
        .st_addr_lo_i  (in_addr[1:0]),
        .st_wdata_i    (in_wdata),
        .st_wmask_o    (st_wmask),
        .st_wdata_o    (st_wdata),
        .st_misalign_o (st_misalign),
        .st_err_o      (st_err),
        .ld_funct3_i   (f3_q),
        .ld_addr_lo_i  (alo_q),
        .ld_rdata_i    (mem_rsp_rdata),
        .ld_data_o     (ld_data)
    );

    assign accept        = in_valid & in_ready;
    assign in_ready      = (state_q == IDLE);
    assign mem_req_valid = (state_q == REQ);
    assign out_valid     = (state_q == RESP);
    assign mem_req_wen   = wen_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_wdata = req_wdata_q;
    assign mem_req_wmask = MASK_W'(req_wmask_q);
    assign out_rdata     = rdata_q;
    assign out_err       = err_q;

    // State register; reset drops any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state: responses are only looked at in WAIT, so a rsp coincident with the
    // request handshake (or arriving while idle) is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = st_misalign ? RESP : REQ;
            REQ:  if (mem_req_ready) state_d = WAIT;
            WAIT: if (mem_rsp_valid) state_d = RESP;
            RESP: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch request fields on accept, capture extracted load data on response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q       <= 1'b0;
            f3_q        <= 3'b000;
            alo_q       <= 2'b00;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wmask_q <= 4'b0000;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else if (accept) begin
            wen_q       <= in_wen;
            f3_q        <= in_funct3;
            alo_q       <= in_addr[1:0];
            req_addr_q  <= {in_addr[XLEN-1:2], 2'b00};
            req_wdata_q <= st_wdata;
            req_wmask_q <= st_wmask;
            rdata_q     <= '0;
            err_q       <= st_err;
        end else if (state_q == WAIT && mem_rsp_valid && !wen_q) begin
            rdata_q     <= ld_data;
        end
    end

endmodule

// File: tb/tb_lsu_mem_req.sv
// tb_lsu_mem_req: directed vectors, randomized ops against a byte-level reference model,
// plus hand-written sequences for reset state, request back-pressure and reset in WAIT.
module tb_lsu_mem_req;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_wen;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_wdata;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_mem_req #(.XLEN(32), .MASK_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rdata(out_rdata), .out_err(out_err)
    );

    typedef struct {
        logic        wen;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rsp;
        int          rdy_dly;
        int          rsp_dly;
        logic [31:0] e_addr;
        logic [7:0]  e_mask;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
        logic        e_err;
        logic        e_skip;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: access size/offset from funct3, bytes gathered one at a time,
    // sign extension by arithmetic on the gathered value.
    function automatic vec_t model(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] rsp,
                                   input int rdy, input int rspd);
        vec_t v;
        int size, off;
        bit sgn;
        longint val;
        v.wen = wen; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rsp = rsp;
        v.rdy_dly = rdy; v.rsp_dly = rspd;
        sgn = 0;
        case (f3)
            3'd0: begin size = 1; sgn = 1; end
            3'd4: size = 1;
            3'd1: begin size = 2; sgn = 1; end
            3'd5: size = 2;
            default: size = 4;
        endcase
        off = (size == 1) ? int'(addr % 4) : (size == 2) ? int'((addr % 4) / 2 * 2) : 0;
        v.e_skip = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        v.e_skip = (size == 2 && addr % 2 != 0) || (size == 4 && addr % 4 != 0);
`endif
        v.e_addr  = addr - (addr % 4);
        v.e_mask  = 8'(((1 << size) - 1) << off);
        v.e_wdata = wdata << (8 * off);
        val = 0;
        for (int k = 0; k < size; k++)
            val = val | (longint'((rsp >> (8 * (off + k))) & 32'hff) << (8 * k));
        if (sgn && val >= (longint'(1) << (8 * size - 1)))
            val = val - (longint'(1) << (8 * size));
        v.e_rdata = (wen || v.e_skip) ? 32'h0 : val[31:0];
        v.e_err   = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) || v.e_skip;
        return v;
    endfunction

    function automatic vec_t mk(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rsp, input int rdy,
                                input logic [31:0] ea, input logic [7:0] em, input logic [31:0] ew,
                                input logic [31:0] er, input logic ee);
        vec_t v;
        v.wen = wen; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rsp = rsp;
        v.rdy_dly = rdy; v.rsp_dly = 0;
        v.e_addr = ea; v.e_mask = em; v.e_wdata = ew; v.e_rdata = er; v.e_err = ee;
        v.e_skip = 1'b0;
        return v;
    endfunction

    // Runs one op end to end; caller and task both sit 1 time unit after a rising edge.
    task automatic run(input vec_t v, input string tag);
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_wen = v.wen; in_funct3 = v.f3; in_addr = v.addr; in_wdata = v.wdata;
        @(posedge clk); #1;
        // Scramble inputs after accept: the request must come from latched copies.
        in_valid = 1'b0; in_wen = ~v.wen; in_funct3 = 3'($urandom);
        in_addr = $urandom; in_wdata = $urandom;
        if (v.e_skip) begin
            chk({tag, " skip req_valid"}, 32'(mem_req_valid), 32'd0);
        end else begin
            for (int i = 0; i <= v.rdy_dly; i++) begin
                chk({tag, " req_valid"}, 32'(mem_req_valid), 32'd1);
                chk({tag, " req_addr"}, mem_req_addr, v.e_addr);
                chk({tag, " req_wen"}, 32'(mem_req_wen), 32'(v.wen));
                if (v.wen) begin
                    chk({tag, " req_wmask"}, 32'(mem_req_wmask), 32'(v.e_mask));
                    chk({tag, " req_wdata"}, mem_req_wdata, v.e_wdata);
                end
                chk({tag, " out_valid early"}, 32'(out_valid), 32'd0);
                if (i == v.rdy_dly) begin
                    // A response coincident with the handshake must be ignored.
                    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_rdata = $urandom;
                end
                @(posedge clk); #1;
                mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
            end
            for (int i = 0; i <= v.rsp_dly; i++) begin
                chk({tag, " wait out_valid"}, 32'(out_valid), 32'd0);
                chk({tag, " wait req_valid"}, 32'(mem_req_valid), 32'd0);
                if (i == v.rsp_dly) begin
                    mem_rsp_valid = 1'b1; mem_rsp_rdata = v.rsp;
                end
                @(posedge clk); #1;
                mem_rsp_valid = 1'b0; mem_rsp_rdata = $urandom;
            end
        end
        for (int i = 0; i < 1 + (v.rsp_dly % 2); i++) begin
            chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
            chk({tag, " out_rdata"}, out_rdata, v.e_rdata);
            chk({tag, " out_err"}, 32'(out_err), 32'(v.e_err));
            chk({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
            if (i == v.rsp_dly % 2) out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        chk({tag, " done out_valid"}, 32'(out_valid), 32'd0);
    endtask

    vec_t tbl[$];
    vec_t rv;
    logic [2:0] f3_pool [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd0, 3'd3, 3'd6, 3'd7};

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_wen = 1'b0; in_funct3 = 3'd0; in_addr = '0; in_wdata = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; out_ready = 1'b0;

        // Reset state
        #2;
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst req_addr", mem_req_addr, 32'd0);
        chk("rst req_wmask", 32'(mem_req_wmask), 32'd0);
        chk("rst req_wdata", mem_req_wdata, 32'd0);
        chk("rst req_wen", 32'(mem_req_wen), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_rdata", out_rdata, 32'd0);
        chk("rst out_err", 32'(out_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors: wen f3 addr wdata rsp rdy | addr mask wdata rdata err
        tbl.push_back(mk(1, 3'd2, 32'h1000, 32'hdeadbeef, 32'h55aa55aa, 0, 32'h1000, 8'h0f, 32'hdeadbeef, 32'h0, 0));
        tbl.push_back(mk(1, 3'd0, 32'h1003, 32'h000000a5, 32'h0, 1, 32'h1000, 8'h08, 32'ha5000000, 32'h0, 0));
        tbl.push_back(mk(0, 3'd0, 32'h1002, 32'h0, 32'h12805634, 0, 32'h1000, 8'h0, 32'h0, 32'hffffff80, 0));
        tbl.push_back(mk(0, 3'd4, 32'h1002, 32'h0, 32'h12805634, 0, 32'h1000, 8'h0, 32'h0, 32'h00000080, 0));
        tbl.push_back(mk(0, 3'd1, 32'h1002, 32'h0, 32'h8001ffff, 3, 32'h1000, 8'h0, 32'h0, 32'hffff8001, 0));
        tbl.push_back(mk(0, 3'd5, 32'h1002, 32'h0, 32'h8001ffff, 0, 32'h1000, 8'h0, 32'h0, 32'h00008001, 0));
        tbl.push_back(mk(0, 3'd2, 32'h1004, 32'h0, 32'h87654321, 2, 32'h1004, 8'h0, 32'h0, 32'h87654321, 0));
        tbl.push_back(mk(1, 3'd1, 32'h2002, 32'h1234abcd, 32'h0, 0, 32'h2000, 8'h0c, 32'habcd0000, 32'h0, 0));
        tbl.push_back(mk(0, 3'd0, 32'h1001, 32'h0, 32'h12805634, 0, 32'h1000, 8'h0, 32'h0, 32'h00000056, 0));
        tbl.push_back(mk(0, 3'd1, 32'h1000, 32'h0, 32'h12808000, 0, 32'h1000, 8'h0, 32'h0, 32'hffff8000, 0));
        tbl.push_back(mk(0, 3'd3, 32'h0010, 32'h0, 32'hcafef00d, 0, 32'h0010, 8'h0, 32'h0, 32'hcafef00d, 1));
        tbl.push_back(mk(1, 3'd7, 32'h0014, 32'h01020304, 32'h0, 0, 32'h0014, 8'h0f, 32'h01020304, 32'h0, 1));
        foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

        // LW @0x1001: misaligned word (skips memory only when the check is built in)
        run(model(0, 3'd2, 32'h1001, 32'h0, 32'h11223344, 0, 0), "lw_misalign");

        // Reset asserted while waiting for the response; the late response is ignored.
        in_valid = 1'b1; in_wen = 1'b0; in_funct3 = 3'd2; in_addr = 32'h3000;
        @(posedge clk); #1;
        in_valid = 1'b0; mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        rst = 1'b1; #2;
        chk("rstwait req_valid", 32'(mem_req_valid), 32'd0);
        chk("rstwait out_valid", 32'(out_valid), 32'd0);
        chk("rstwait in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hbad0bad0;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        chk("late rsp out_valid", 32'(out_valid), 32'd0);
        chk("late rsp in_ready", 32'(in_ready), 32'd1);

        // Randomized ops against the reference model
        for (int n = 0; n < 150; n++) begin
            rv = model(1'($urandom), f3_pool[$urandom_range(0, 9)], $urandom, $urandom, $urandom,
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            run(rv, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
